// File: rtl/sd_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : sd_decimator
//  Purpose  : 1-bit sigma-delta bitstream to 16-bit PCM decimator using a
//             second-order CIC (sinc^2) filter, decimation R = 2^LOG2R,
//             with saturating rescale to signed and offset-binary outputs.
//  Revision : 1.0  initial release
// ============================================================================
module sd_decimator #(
  parameter int LOG2R = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bit_in,
  input  logic        bit_en,
  input  logic        clr,
  output logic [15:0] pcm,
  output logic [15:0] pcm_u,
  output logic        pcm_valid
);

  // Filter word width: enough to hold R^2 exactly, everything else wraps.
  localparam int W     = 2 * LOG2R + 1;
  localparam int SHIFT = 16 - 2 * LOG2R;
  // Mid-scale of the comb output (R^2 / 2), used to centre y around zero.
  localparam logic signed [17:0] HALF = 18'sd1 <<< (2 * LOG2R - 1);

  logic [W-1:0]     i1;
  logic [W-1:0]     i2;
  logic [W-1:0]     i1_next;
  logic [LOG2R-1:0] phase;
  logic             dec_point;
  logic             dec;

  logic [W-1:0]     i2_prev;
  logic [W-1:0]     c1;
  logic             s1_vld;
  logic [W-1:0]     c1_prev;
  logic [W-1:0]     y;
  logic             s2_vld;

  logic             warm_done;
  logic signed [17:0] centered;
  logic signed [17:0] scaled;
  logic [15:0]      sat;

  assign i1_next   = i1 + W'(bit_in);
  assign dec_point = bit_en && (phase == {LOG2R{1'b1}});

  // Integrators and decimation phase; frozen whenever bit_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1    <= '0;
      i2    <= '0;
      phase <= '0;
      dec   <= 1'b0;
    end else if (clr) begin
      i1    <= '0;
      i2    <= '0;
      phase <= '0;
      dec   <= 1'b0;
    end else begin
      dec <= dec_point;
      if (bit_en) begin
        i1    <= i1_next;
        i2    <= i2 + i1_next;
        phase <= phase + LOG2R'(1);
      end
    end
  end

  // First comb stage: differentiate the second integrator at the low rate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i2_prev <= '0;
      c1      <= '0;
      s1_vld  <= 1'b0;
    end else if (clr) begin
      i2_prev <= '0;
      c1      <= '0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= dec;
      if (dec) begin
        c1      <= i2 - i2_prev;
        i2_prev <= i2;
      end
    end
  end

  // Second comb stage: yields y in [0, R^2] once the filter has filled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1_prev <= '0;
      y       <= '0;
      s2_vld  <= 1'b0;
    end else if (clr) begin
      c1_prev <= '0;
      y       <= '0;
      s2_vld  <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        y       <= c1 - c1_prev;
        c1_prev <= c1;
      end
    end
  end

  // Centre, scale to 16-bit full range and clip; only y = R^2 can overflow.
  always_comb begin
    centered = $signed({{(18 - W){1'b0}}, y}) - HALF;
    scaled   = centered <<< SHIFT;
    if (scaled > 18'sd32767) begin
      sat = 16'h7FFF;
    end else if (scaled < -18'sd32768) begin
      sat = 16'h8000;
    end else begin
      sat = scaled[15:0];
    end
  end

  // Output register: first sample after reset/clr is a partial fill, drop it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm       <= 16'h0000;
      pcm_valid <= 1'b0;
      warm_done <= 1'b0;
    end else if (clr) begin
      pcm_valid <= 1'b0;
      warm_done <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      if (s2_vld) begin
        warm_done <= 1'b1;
        if (warm_done) begin
          pcm       <= sat;
          pcm_valid <= 1'b1;
        end
      end
    end
  end

  assign pcm_u = pcm ^ 16'h8000;

endmodule
`default_nettype wire

// File: tb/tb_sd_decimator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_decimator
//  Purpose  : Directed self-checking bench; three decimators (LOG2R = 4, 6, 8)
//             share one stimulus stream, each checked at its own timing.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sd_decimator;

  logic        clk;
  logic        rst;
  logic        bit_in;
  logic        bit_en;
  logic        clr;
  logic [15:0] pcm_a   [3];
  logic [15:0] pcmu_a  [3];
  logic        valid_a [3];

  // Index 0: LOG2R=4 (R=16), 1: LOG2R=6 (R=64), 2: LOG2R=8 (R=256)
  sd_decimator #(.LOG2R(4)) u_dut4 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clr(clr),
    .pcm(pcm_a[0]), .pcm_u(pcmu_a[0]), .pcm_valid(valid_a[0]));
  sd_decimator #(.LOG2R(6)) u_dut6 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clr(clr),
    .pcm(pcm_a[1]), .pcm_u(pcmu_a[1]), .pcm_valid(valid_a[1]));
  sd_decimator #(.LOG2R(8)) u_dut8 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clr(clr),
    .pcm(pcm_a[2]), .pcm_u(pcmu_a[2]), .pcm_valid(valid_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int t;            // edges since reset release; edge 1 samples bit 1

  // Stimulus generator state
  logic        active;
  logic [7:0]  pat;
  int          pat_len;
  int          pat_idx;
  int          en_div;
  int          en_cnt;
  logic        idle_bit;
  logic        sd_mode;
  logic [15:0] sd_x;
  logic [15:0] sd_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compute the inputs presented to the next clock edge.
  task drive_next();
    logic [16:0] sum;
    if (!active) begin
      bit_en = 1'b0;
      bit_in = 1'b0;
    end else begin
      bit_en = (en_cnt == 0);
      en_cnt = (en_cnt + 1 == en_div) ? 0 : en_cnt + 1;
      if (bit_en) begin
        if (sd_mode) begin
          sum    = {1'b0, sd_acc} + {1'b0, sd_x};
          sd_acc = sum[15:0];
          bit_in = sum[16];
        end else begin
          bit_in  = pat[pat_idx];
          pat_idx = (pat_idx + 1 == pat_len) ? 0 : pat_idx + 1;
        end
      end else begin
        bit_in = idle_bit;
      end
    end
  endtask

  task step();
    @(posedge clk);
    #1;
    t++;
    drive_next();
  endtask

  task run_to(input int n);
    while (t < n) step();
  endtask

  task set_stim(input logic [7:0] p, input int len, input int div,
                input logic idle, input logic sd);
    pat      = p;
    pat_len  = len;
    en_div   = div;
    idle_bit = idle;
    sd_mode  = sd;
    sd_x     = 16'h4000;
  endtask

  task reset_dut(input logic check_vals);
    active = 1'b0;
    clr    = 1'b0;
    rst    = 1'b1;
    step();
    step();
    if (check_vals) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("reset_pcm[%0d]", k), 32'(pcm_a[k]), 32'h0000);
        check($sformatf("reset_pcm_u[%0d]", k), 32'(pcmu_a[k]), 32'h8000);
        check($sformatf("reset_valid[%0d]", k), 32'(valid_a[k]), 32'h0);
      end
    end
    en_cnt  = 0;
    pat_idx = 0;
    sd_acc  = 16'h0000;
    rst     = 1'b0;
    t       = 0;
    active  = 1'b1;
    drive_next();
  endtask

  // Step until the chosen DUT strobes; at = edge index, or -1 on timeout.
  task wait_strobe(input int idx, input int limit, output int at);
    at = -1;
    while (at < 0 && t < limit) begin
      step();
      if (valid_a[idx]) at = t;
    end
  endtask

  typedef struct {
    logic [7:0]  p;
    int          len;
    logic [15:0] exp_pcm;
  } pat_vec_t;

  pat_vec_t pvec [3];
  int       at;
  logic     saw;
  logic     in_range;

  initial begin
    rst = 1'b1; clr = 1'b0; bit_in = 1'b0; bit_en = 1'b0;
    t = 0; active = 1'b0;
    set_stim(8'h01, 1, 1, 1'b0, 1'b0);

    // Constant ones: warm-up, latency, saturation (LOG2R=4 and 6)
    reset_dut(1'b1);
    wait_strobe(0, 100, at);
    check("ones4_time", 32'(at), 32'd35);
    check("ones4_pcm", 32'(pcm_a[0]), 32'h7FFF);
    wait_strobe(1, 200, at);
    check("ones6_time", 32'(at), 32'd131);
    check("ones6_pcm", 32'(pcm_a[1]), 32'h7FFF);
    check("ones6_pcm_u", 32'(pcmu_a[1]), 32'hFFFF);
    step();
    check("ones6_strobe_one_cycle", 32'(valid_a[1]), 32'h0);
    wait_strobe(1, 300, at);
    check("ones6_time2", 32'(at), 32'd195);
    check("ones6_pcm2", 32'(pcm_a[1]), 32'h7FFF);

    // Constant zeros: negative full scale, zero-shift path at LOG2R=8
    set_stim(8'h00, 1, 1, 1'b0, 1'b0);
    reset_dut(1'b0);
    wait_strobe(0, 100, at);
    check("zeros4_time", 32'(at), 32'd35);
    check("zeros4_pcm", 32'(pcm_a[0]), 32'h8000);
    wait_strobe(1, 200, at);
    check("zeros6_time", 32'(at), 32'd131);
    check("zeros6_pcm", 32'(pcm_a[1]), 32'h8000);
    check("zeros6_pcm_u", 32'(pcmu_a[1]), 32'h0000);
    wait_strobe(2, 600, at);
    check("zeros8_time", 32'(at), 32'd515);
    check("zeros8_pcm", 32'(pcm_a[2]), 32'h8000);

    // Repeating patterns: duty 1/2, 1/4, 3/4
    pvec[0] = '{8'b0000_0001, 2, 16'h0000};
    pvec[1] = '{8'b0000_0001, 4, 16'hC000};
    pvec[2] = '{8'b0000_0111, 4, 16'h4000};
    for (int k = 0; k < 3; k++) begin
      set_stim(pvec[k].p, pvec[k].len, 1, 1'b0, 1'b0);
      reset_dut(1'b0);
      wait_strobe(1, 200, at);
      check($sformatf("pat%0d_time", k), 32'(at), 32'd131);
      check($sformatf("pat%0d_pcm", k), 32'(pcm_a[1]), 32'(pvec[k].exp_pcm));
    end

    // bit_en one cycle in three, ones, idle bit 0
    set_stim(8'h01, 1, 3, 1'b0, 1'b0);
    reset_dut(1'b0);
    wait_strobe(1, 500, at);
    check("en3_time", 32'(at), 32'd385);
    check("en3_pcm", 32'(pcm_a[1]), 32'h7FFF);
    step();
    wait_strobe(1, 700, at);
    check("en3_spacing", 32'(at), 32'd577);
    check("en3_pcm2", 32'(pcm_a[1]), 32'h7FFF);

    // bit_en one in three, pattern 1,0, idle bit 1 must be ignored
    set_stim(8'h01, 2, 3, 1'b1, 1'b0);
    reset_dut(1'b0);
    wait_strobe(1, 500, at);
    check("en3_idle_time", 32'(at), 32'd385);
    check("en3_idle_pcm", 32'(pcm_a[1]), 32'h0000);

    // Loopback from a first-order sigma-delta fed 0x4000 offset binary
    set_stim(8'h00, 1, 1, 1'b0, 1'b1);
    reset_dut(1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_strobe(1, 300, at);
      check($sformatf("loop_time%0d", k), 32'(at), 32'(131 + 64 * k));
      in_range = (pcmu_a[1] >= 16'h4000 - 16'd64) && (pcmu_a[1] <= 16'h4000 + 16'd64);
      if (!in_range)
        $display("FAIL loop_pcm_u%0d: got 0x%0h required 0x4000 +/- 64", k, pcmu_a[1]);
      check($sformatf("loop_range%0d", k), 32'(in_range), 32'h1);
    end

    // clr on a phase-15 edge, LOG2R=4, ones: pcm holds, warm-up re-armed
    set_stim(8'h01, 1, 1, 1'b0, 1'b0);
    reset_dut(1'b0);
    wait_strobe(0, 100, at);
    check("clr4_first", 32'(at), 32'd35);
    run_to(63);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr4_valid_low", 32'(valid_a[0]), 32'h0);
    check("clr4_pcm_hold", 32'(pcm_a[0]), 32'h7FFF);
    wait_strobe(0, 200, at);
    check("clr4_next_strobe", 32'(at), 32'd99);
    check("clr4_pcm", 32'(pcm_a[0]), 32'h7FFF);

    // clr on a phase-255 edge, LOG2R=8, zeros
    set_stim(8'h00, 1, 1, 1'b0, 1'b0);
    reset_dut(1'b0);
    wait_strobe(2, 600, at);
    check("clr8_first", 32'(at), 32'd515);
    run_to(767);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr8_valid_low", 32'(valid_a[2]), 32'h0);
    check("clr8_pcm_hold", 32'(pcm_a[2]), 32'h8000);
    wait_strobe(2, 1400, at);
    check("clr8_next_strobe", 32'(at), 32'd1283);
    check("clr8_pcm", 32'(pcm_a[2]), 32'h8000);

    // Async reset between dec (edge 48) and its output edge (51), LOG2R=4
    set_stim(8'h01, 1, 1, 1'b0, 1'b0);
    reset_dut(1'b0);
    wait_strobe(0, 100, at);
    check("rst4_first", 32'(at), 32'd35);
    run_to(49);
    rst = 1'b1;
    #1;
    check("rst4_pcm", 32'(pcm_a[0]), 32'h0000);
    check("rst4_pcm_u", 32'(pcmu_a[0]), 32'h8000);
    check("rst4_valid", 32'(valid_a[0]), 32'h0);
    saw = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (valid_a[0]) saw = 1'b1;
    end
    check("rst4_no_strobe", 32'(saw), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sd_decimator.md
# sd_decimator

Sigma-delta bitstream decimator: the receive-side counterpart of the audio mixer's first-order sigma-delta PWM modulator. It takes a 1-bit density-modulated stream, either a looped-back `pwm_out` or an external 1-bit ADC/tape input, and recovers 16-bit PCM samples. It uses a second-order CIC (sinc²) filter with a power-of-two decimation ratio and a saturating rescale to signed and offset-binary 16-bit. Output samples are qualified by a one-cycle strobe so they can feed the mixer or a capture FIFO directly.

## Interface
- `LOG2R`, default 6: log2 of decimation ratio R. Legal values are 4..8; R = 2^LOG2R.
- `clk` input 1: system clock; everything is synchronous to it.
- `rst` input 1: reset, asynchronous and active-high.
- `bit_in` input 1: bitstream sample; 1 = positive pulse.
- `bit_en` input 1: `bit_in` is consumed only on cycles where `bit_en` = 1. Tie it to 1 for one bit per `clk`.
- `clr` input 1: synchronous restart of the filter and phase. Same effect as reset, without the async path.
- `pcm` output 16: recovered sample, signed two's complement.
- `pcm_u` output 16: same sample, offset binary (`pcm` ^ 16'h8000).
- `pcm_valid` output 1: one-cycle strobe; `pcm`/`pcm_u` are updated on the same edge.

## Operation
- Width W = 2·LOG2R + 1. All integrator and comb registers are W-bit unsigned with modular (wrap-around) arithmetic. Wrap is required and correct for CIC; no saturation is applied inside the filter.
- Integrators, updated only on `bit_en` cycles:
  - i1 ← i1 + bit_in
  - i2 ← i2 + i1_next, where i1_next is the value of i1 including the current bit.
- Phase counter: LOG2R bits, advances on each `bit_en` and wraps R−1 → 0. The `bit_en` cycle with phase = R−1 is the decimation point; it raises internal strobe `dec`.
- Decimated pipeline, one stage per clock, advancing only behind `dec`:
  - Stage 1: c1 = i2 − i2_prev; i2_prev ← i2.
  - Stage 2: y = c1 − c1_prev; c1_prev ← c1.
  - Stage 3: output stage.
- Output stage:
  - y is in [0, R²].
  - s = (y − R²/2) << (16 − 2·LOG2R), computed signed at 18 bits.
  - s > 32767 saturates to 32767; s < −32768 saturates to −32768. The only reachable saturation case is y = R², which gives +32768 → 16'h7FFF.
- Warm-up: the first decimated output after reset or `clr` is discarded. `pcm` is not updated and `pcm_valid` stays 0. Every later decimation point produces exactly one `pcm_valid`.
- `clr` = 1 on any edge:
  - Clears integrators, combs, delays, phase and pipeline strobes, and re-arms warm-up.
  - `pcm` and `pcm_u` hold their last values.
  - `pcm_valid` is forced to 0.
  - `clr` wins over a simultaneous `bit_en`/`dec`; that bit is dropped.
- `bit_en` = 0 stalls integrators and phase only. A `dec` already in the pipeline still completes.

## Timing
- Reset values:
  - `pcm` = 16'h0000, `pcm_u` = 16'h8000, `pcm_valid` = 0.
  - Integrators, combs, delays and phase = 0; warm-up armed.
- Latency: if edge E samples the phase-R−1 bit, `pcm`/`pcm_valid` update on edge E+3. `pcm_valid` is high for exactly the cycle following E+3.
- Maximum output rate: one sample per R `bit_en` cycles. With R ≥ 16 the 3-stage pipeline never holds two samples.
- Async `rst` mid-pipeline drops any in-flight sample; no `pcm_valid` follows.
- Steady-state constant duty d gives y = d·R², exact from the second decimated output onward.

## Test plan
- LOG2R=6, `bit_en`=1, `bit_in`=1 constant from reset:
  - No strobe for the first 64 bits.
  - At the 128th bit plus 3 cycles, `pcm`=16'h7FFF, `pcm_u`=16'hFFFF.
  - Then one strobe every 64 cycles, value unchanged.
- `bit_in`=0 constant → `pcm`=16'h8000 and `pcm_u`=16'h0000 on every strobe after warm-up.
- Repeating 1,0 → `pcm`=16'h0000. Repeating 1,0,0,0 → `pcm`=16'hC000. Repeating 1,1,1,0 → `pcm`=16'h4000.
- `bit_en` high one cycle in three, `bit_in`=1 → strobes spaced 192 clocks apart, values 16'h7FFF. Integrator values frozen on idle cycles.
- Loopback: first-order sigma-delta model fed constant 16'h4000 (offset binary) → decoded `pcm_u` within ±64 LSB of 16'h4000 after warm-up.
- Boundary checks, with LOG2R=4 and LOG2R=8 on constant ones/zeros:
  - `clr` asserted on the same edge as a phase-R−1 bit → no strobe for that period or the next (warm-up re-armed), `pcm` holds.
  - Async `rst` asserted between `dec` and E+3 → no strobe, outputs return to reset values immediately.
  - LOG2R=4 and LOG2R=8 give 16'h7FFF and 16'h8000 respectively (saturation and zero-shift paths).
